button_event_classifier: RTL and testbench

Consumes the debounced, active-high level from the debouncer stage and classifies each button gesture as a short press, a long press or a double click. It emits one single-cycle pulse per gesture to the control logic downstream. Everything runs in one clock domain, and all outputs are registered.

---
 rtl/button_event_classifier_pkg.sv | 27 ++
 rtl/button_event_classifier_if.sv | 41 ++++
 rtl/button_event_classifier.sv | 146 ++++++++++++++
 tb/tb_button_event_classifier.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_classifier_pkg
// Purpose  : Shared types for the button gesture classifier: the FSM state
//            encoding and the gesture codes consumed by downstream control.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package button_event_classifier_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PRESS1 = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  // Gesture codes for downstream logic that encodes the three pulses.
  localparam logic [1:0] GESTURE_NONE   = 2'd0;
  localparam logic [1:0] GESTURE_SHORT  = 2'd1;
  localparam logic [1:0] GESTURE_LONG   = 2'd2;
  localparam logic [1:0] GESTURE_DOUBLE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/button_event_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : button_event_classifier_if
// Purpose  : Bundles the debounced button level and the classified gesture
//            pulses between the producer/consumer side and the classifier.
// Signals  : clean_in     - debounced button level (1 = pressed)
//            short_press  - one-cycle short press pulse
//            long_press   - one-cycle long press pulse
//            double_click - one-cycle double click pulse
//            busy         - classifier is not idle
// Modports : master - drives clean_in, observes the results
//            slave  - the classifier itself
// Revision : 1.0 - initial release
// ============================================================================
interface button_event_classifier_if;
  import button_event_classifier_pkg::*;

  logic clean_in;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  modport master (
    output clean_in,
    input  short_press,
    input  long_press,
    input  double_click,
    input  busy
  );

  modport slave (
    input  clean_in,
    output short_press,
    output long_press,
    output double_click,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/button_event_classifier.sv
`default_nettype none
// ============================================================================
// Module   : button_event_classifier
// Purpose  : Classifies debounced button gestures into short press, long
//            press or double click and emits one registered single-cycle
//            pulse per gesture.
// Ports    : clk     - system clock, all sampling on posedge
//            reset_n - asynchronous active-low reset
//            bus     - slave modport: clean_in in; short_press, long_press,
//                      double_click, busy out (all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module button_event_classifier
  import button_event_classifier_pkg::*;
#(
  parameter int LONG_CYCLES   = 16_000_000,
  parameter int DCLICK_CYCLES = 5_000_000,
  parameter int CNT_WIDTH     = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  button_event_classifier_if.slave    bus
);

  localparam longint MAX_CYCLES = (LONG_CYCLES > DCLICK_CYCLES) ?
                                  longint'(LONG_CYCLES) : longint'(DCLICK_CYCLES);

  generate
    if ((LONG_CYCLES < 2) || (DCLICK_CYCLES < 2) ||
        (MAX_CYCLES >= (64'sd1 <<< CNT_WIDTH))) begin : g_param_check
      $error("button_event_classifier: illegal LONG_CYCLES/DCLICK_CYCLES/CNT_WIDTH");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DCLICK_LAST = CNT_WIDTH'(DCLICK_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 double_q, double_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  // The counter only increments while below its state's terminal value, so
  // it saturates at max(LONG_CYCLES, DCLICK_CYCLES)-1 by construction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        // A level already high out of reset is ignored until it drops.
        cnt_d = '0;
        if (!bus.clean_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.clean_in) begin
          state_d = ST_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS1: begin
        if (bus.clean_in) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_ONE;
        end
      end
      ST_GAP: begin
        if (bus.clean_in) begin
          state_d = ST_PRESS2;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESS2: begin
        // Holding the second press long still reports a double click only.
        if (!bus.clean_in) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == LONG_LAST) begin
          double_d = 1'b1;
          state_d  = ST_HOLD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (!bus.clean_in) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // Decoding the next state keeps busy aligned with the state register.
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_click = double_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_classifier
// Purpose  : Self-checking bench for button_event_classifier. A run-length
//            reference model predicts gesture pulses and busy; a monitor
//            compares them against the DUT outputs cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_classifier;
  import button_event_classifier_pkg::*;

  localparam int LONG   = 8;
  localparam int DCLICK = 4;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct { logic [1:0] code; int cyc; } ev_t;
  typedef struct { bit b; int cyc; } busy_t;

  ev_t   evq[$];
  busy_t bq[$];

  // Reference model state: gesture history since the gesture began.
  bit armed;
  bit holding;
  bit hist[$];

  button_event_classifier_if bif ();

  button_event_classifier #(
    .LONG_CYCLES   (LONG),
    .DCLICK_CYCLES (DCLICK),
    .CNT_WIDTH     (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    armed   = 1'b0;
    holding = 1'b0;
    hist.delete();
  endtask

  // Classifies from the run lengths of the current gesture: H^a, H^a L^b,
  // H^a L^b H^c, H^a L^b H^c L^d.
  task automatic model_step(input bit v, output logic [1:0] code, output bit busy_e);
    int r[$];
    code = GESTURE_NONE;
    if (!armed) begin
      if (!v) armed = 1'b1;
      busy_e = !armed;
    end else if (holding) begin
      if (!v) holding = 1'b0;
      busy_e = holding;
    end else if (hist.size() == 0 && !v) begin
      busy_e = 1'b0;
    end else begin
      hist.push_back(v);
      for (int i = 0; i < hist.size(); i++) begin
        if (i == 0 || hist[i] != hist[i-1]) r.push_back(1);
        else r[r.size()-1] = r[r.size()-1] + 1;
      end
      case (r.size())
        1: if (r[0] == LONG)   begin code = GESTURE_LONG;   holding = 1'b1; hist.delete(); end
        2: if (r[1] == DCLICK) begin code = GESTURE_SHORT;  hist.delete(); end
        3: if (r[2] == LONG)   begin code = GESTURE_DOUBLE; holding = 1'b1; hist.delete(); end
        4:                     begin code = GESTURE_DOUBLE; hist.delete(); end
        default: ;
      endcase
      busy_e = holding || (hist.size() != 0);
    end
  endtask

  task automatic drive(input bit v, input int n);
    logic [1:0] code;
    bit         be;
    ev_t        e;
    busy_t      b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bif.clean_in = v;
      model_step(v, code, be);
      b.b   = be;
      b.cyc = cyc + 1;
      bq.push_back(b);
      if (code != GESTURE_NONE) begin
        e.code = code;
        e.cyc  = cyc + 1;
        evq.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bif.short_press !== 1'b0 || bif.long_press !== 1'b0 ||
        bif.double_click !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s: got sp=%b lp=%b dc=%b busy=%b, want 0 0 0 1",
               name, bif.short_press, bif.long_press, bif.double_click, bif.busy);
    end
  endtask

  // Monitor: pops expected pulses/busy whenever the DUT presents a result.
  initial begin : monitor
    int         n;
    logic [1:0] got;
    ev_t        e;
    busy_t      b;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        n = int'(bif.short_press) + int'(bif.long_press) + int'(bif.double_click);
        got = bif.short_press ? GESTURE_SHORT :
              bif.long_press  ? GESTURE_LONG  :
              bif.double_click ? GESTURE_DOUBLE : GESTURE_NONE;
        if (n > 1) begin
          checks++;
          failures++;
          $display("FAIL onehot: %0d pulses high at cycle %0d, want at most 1", n, cyc);
        end
        if (n != 0) begin
          checks++;
          if (evq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: code %0d at cycle %0d, want none", got, cyc);
          end else begin
            e = evq.pop_front();
            if (e.code != got || e.cyc != cyc) begin
              failures++;
              $display("FAIL gesture: code %0d at cycle %0d, want code %0d at cycle %0d",
                       got, cyc, e.code, e.cyc);
            end
          end
        end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
          e = evq.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_pulse: no pulse at cycle %0d, want code %0d", cyc, e.code);
        end
        while (bq.size() != 0 && bq[0].cyc < cyc) begin
          b = bq.pop_front();
          checks++;
          failures++;
          $display("FAIL busy_skip: busy for cycle %0d not observed, want %b", b.cyc, b.b);
        end
        if (bq.size() != 0 && bq[0].cyc == cyc) begin
          b = bq.pop_front();
          checks++;
          if (bif.busy !== b.b) begin
            failures++;
            $display("FAIL busy: got %b at cycle %0d, want %b", bif.busy, cyc, b.b);
          end
        end
      end
    end
  end

  initial begin : stimulus
    cyc          = 0;
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    bif.clean_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // Level high through reset release must never be classified.
    drive(1'b1, 20);
    drive(1'b0, 5);
    // Short press.
    drive(1'b1, 3);
    drive(1'b0, 10);
    // Long press, held, released.
    drive(1'b1, 18);
    drive(1'b0, 5);
    // Double click.
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 2);
    drive(1'b0, 6);
    // Boundaries: LONG-1 is short, LONG is long.
    drive(1'b1, LONG - 1);
    drive(1'b0, 6);
    drive(1'b1, LONG);
    drive(1'b0, 6);
    // Gap of DCLICK-1 lows still joins a double; second press held long.
    drive(1'b1, 2);
    drive(1'b0, DCLICK - 1);
    drive(1'b1, LONG + 3);
    drive(1'b0, 3);
    // Third press right after a double click starts a new gesture.
    drive(1'b1, 2);
    drive(1'b0, 1);
    drive(1'b1, 1);
    drive(1'b0, 1);
    drive(1'b1, 2);
    drive(1'b0, 8);

    // Reset in the middle of GAP aborts the gesture.
    drive(1'b1, 3);
    drive(1'b0, 2);
    @(negedge clk);
    reset_n      = 1'b0;
    bif.clean_in = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset_mid_gap");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 6);
    drive(1'b1, 3);
    drive(1'b0, 8);

    // Randomized gesture stream.
    for (int i = 0; i < 60; i++) begin
      drive(i[0] ? 1'b0 : 1'b1, int'($urandom_range(1, 12)));
    end
    drive(1'b0, 12);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (evq.size() != 0 || bq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d pulses and %0d busy entries pending, want 0 0",
               evq.size(), bq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
